// File: rtl/reg_bus_master_if.sv
// Command/response byte streams plus the register-bus signals of reg_bus_master.
interface reg_bus_master_if #(
   parameter int pBYTECNT_SIZE = 7
);
   logic [7:0]               rx_data;
   logic                     rx_valid;
   logic                     rx_ready;
   logic [7:0]               tx_data;
   logic                     tx_valid;
   logic                     tx_ready;
   logic [7:0]               reg_address;
   logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
   logic [7:0]               reg_datai;
   logic [7:0]               reg_datao;
   logic                     reg_read;
   logic                     reg_write;
   logic                     busy;
   logic                     error;

   modport master (
      input  rx_data, rx_valid, tx_ready, reg_datao,
      output rx_ready, tx_data, tx_valid, reg_address, reg_bytecnt,
             reg_datai, reg_read, reg_write, busy, error
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, reg_datao,
      input  rx_ready, tx_data, tx_valid, reg_address, reg_bytecnt,
             reg_datai, reg_read, reg_write, busy, error
   );
endinterface

// File: rtl/reg_bus_master.sv
// Decodes cmd/addr/len frames into register-bus strobes; writes strobe the cycle after
// each data byte, reads capture reg_datao in zero added cycles and stall while tx is full.
module reg_bus_master #(
   parameter int pBYTECNT_SIZE = 7
) (
   input  logic             clk_usb,
   input  logic             reset_i,
   reg_bus_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, ADDR, LEN, WDATA, RDATA} state_t;

   state_t                   state, state_nxt;
   logic                     rdy_en;
   logic                     is_read;
   logic                     error_q;
   logic                     write_q;
   logic                     tx_valid_q;
   logic [7:0]               len_q;
   logic [7:0]               idx_q;
   logic [7:0]               idx_inc;
   logic [7:0]               addr_q;
   logic [7:0]               datai_q;
   logic [7:0]               tx_data_q;
   logic [pBYTECNT_SIZE-1:0] bytecnt_q;
   logic                     rx_fire;
   logic                     rd_fire;
   logic                     last_byte;

   // rdy_en keeps rx_ready low for the cycle right after a reset edge.
   assign bus.rx_ready = rdy_en && (state != RDATA);
   assign rx_fire      = bus.rx_valid && bus.rx_ready;
   assign rd_fire      = (state == RDATA) && (!tx_valid_q || bus.tx_ready);
   assign idx_inc      = idx_q + 8'd1;
   assign last_byte    = (idx_inc == len_q);

   assign bus.reg_read    = rd_fire;
   assign bus.reg_write   = write_q;
   assign bus.reg_address = addr_q;
   assign bus.reg_bytecnt = bytecnt_q;
   assign bus.reg_datai   = datai_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.tx_valid    = tx_valid_q;
   assign bus.busy        = (state != IDLE) || tx_valid_q;
   assign bus.error       = error_q;

   always_ff @(posedge clk_usb) begin
      if (reset_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rx_fire && bus.rx_data[6:0] == 7'd0) state_nxt = ADDR;
         ADDR:    if (rx_fire) state_nxt = LEN;
         LEN: begin
            if (rx_fire) begin
               if (bus.rx_data == 8'd0) state_nxt = IDLE;
               else if (is_read)        state_nxt = RDATA;
               else                     state_nxt = WDATA;
            end
         end
         WDATA:   if (rx_fire && last_byte) state_nxt = IDLE;
         RDATA:   if (rd_fire && last_byte) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_usb) begin
      if (reset_i) begin
         rdy_en     <= 1'b0;
         is_read    <= 1'b0;
         error_q    <= 1'b0;
         write_q    <= 1'b0;
         tx_valid_q <= 1'b0;
         len_q      <= 8'd0;
         idx_q      <= 8'd0;
         addr_q     <= 8'd0;
         datai_q    <= 8'd0;
         tx_data_q  <= 8'd0;
         bytecnt_q  <= '0;
      end else begin
         rdy_en  <= 1'b1;
         write_q <= 1'b0;
         if (rx_fire) begin
            case (state)
               IDLE: begin
                  if (bus.rx_data[6:0] != 7'd0) error_q <= 1'b1;
                  else                          is_read <= bus.rx_data[7];
               end
               ADDR: addr_q <= bus.rx_data;
               LEN: begin
                  len_q     <= bus.rx_data;
                  idx_q     <= 8'd0;
                  bytecnt_q <= '0;
               end
               WDATA: begin
                  datai_q   <= bus.rx_data;
                  bytecnt_q <= idx_q[pBYTECNT_SIZE-1:0];
                  write_q   <= 1'b1;
                  idx_q     <= idx_inc;
               end
               default: ;
            endcase
         end
         // During reads bytecnt tracks the index of the byte being fetched right now.
         if (rd_fire) begin
            tx_data_q  <= bus.reg_datao;
            tx_valid_q <= 1'b1;
            idx_q      <= idx_inc;
            bytecnt_q  <= idx_inc[pBYTECNT_SIZE-1:0];
         end else if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboarded bench for reg_bus_master: frame table plus hand-written corner sequences.
module tb_reg_bus_master;
   localparam int BW = 7;

   logic clk_usb = 1'b0;
   logic reset_i = 1'b1;
   always #5 clk_usb = ~clk_usb;

   reg_bus_master_if #(.pBYTECNT_SIZE(BW)) bus ();
   reg_bus_master #(.pBYTECNT_SIZE(BW)) dut (.clk_usb(clk_usb), .reset_i(reset_i), .bus(bus));

   typedef struct packed {
      logic [7:0] addr;
      logic [6:0] bc;
      logic [7:0] data;
   } wr_exp_t;

   typedef struct {
      logic       rd;
      logic [7:0] addr;
      int         len;
      logic [7:0] base;
      logic [7:0] step;
   } vec_t;

   wr_exp_t    wq[$];
   logic [7:0] rq[$];
   int checks = 0, failures = 0, cyc = 0;
   int wr_cnt, rd_cnt, wr_first, wr_last, rd_first, rd_last, exp_rd_idx;
   logic [7:0] cur_addr = 8'd0;
   logic mon_en = 1'b0;

   // Slave register model: 0x11223344 at address 0x04, a fixed pattern elsewhere.
   function automatic logic [7:0] rd_model(input logic [7:0] a, input logic [6:0] bc);
      logic [31:0] w;
      w = 32'h11223344;
      if (a == 8'h04 && bc < 7'd4) return w[int'(bc[1:0])*8 +: 8];
      return {a[3:0], bc[3:0]} ^ 8'h5A;
   endfunction

   assign bus.reg_datao = rd_model(bus.reg_address, bus.reg_bytecnt);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk_usb) cyc++;

   always @(negedge clk_usb) begin
      if (mon_en) begin
         if (bus.reg_write) begin
            wr_exp_t e;
            wr_cnt++;
            if (wr_first < 0) wr_first = cyc;
            wr_last = cyc;
            if (wq.size() == 0) check("unexpected_write", 1, 0);
            else begin
               e = wq.pop_front();
               check("wr_addr", bus.reg_address, e.addr);
               check("wr_bytecnt", bus.reg_bytecnt, e.bc);
               check("wr_data", bus.reg_datai, e.data);
            end
         end
         if (bus.reg_read) begin
            rd_cnt++;
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
            check("rd_wr_exclusive", bus.reg_write, 0);
            check("rd_addr", bus.reg_address, cur_addr);
            check("rd_bytecnt", bus.reg_bytecnt, exp_rd_idx[6:0]);
            exp_rd_idx++;
         end
         if (bus.tx_valid && bus.tx_ready) begin
            if (rq.size() == 0) check("unexpected_tx", 1, 0);
            else                check("tx_data", bus.tx_data, rq.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      for (n = 0; n < 200; n++) begin
         @(negedge clk_usb);
         if (bus.rx_ready) break;
      end
      if (n >= 200) check("rx_ready_timeout", 0, 1);
      @(posedge clk_usb); #1;
   endtask

   task automatic send_frame(input logic rd, input logic [7:0] addr, input int len,
                             input logic [7:0] base, input logic [7:0] step);
      send_byte(rd ? 8'h80 : 8'h00);
      send_byte(addr);
      send_byte(8'(len));
      if (!rd) for (int k = 0; k < len; k++) send_byte(8'(base + k * step));
      bus.rx_valid = 1'b0;
   endtask

   task automatic expect_frame(input logic rd, input logic [7:0] addr, input int len,
                               input logic [7:0] base, input logic [7:0] step);
      for (int k = 0; k < len; k++) begin
         if (rd) rq.push_back(rd_model(addr, 7'(k)));
         else    wq.push_back('{addr: addr, bc: 7'(k), data: 8'(base + k * step)});
      end
   endtask

   task automatic begin_frame(input logic [7:0] addr);
      cur_addr   = addr;
      exp_rd_idx = 0;
      wr_cnt = 0; rd_cnt = 0;
      wr_first = -1; rd_first = -1; wr_last = -1; rd_last = -1;
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 2000; n++) begin
         @(negedge clk_usb);
         if (!bus.busy && wq.size() == 0 && rq.size() == 0) break;
      end
      check("idle_timeout", 32'(n < 2000), 1);
      @(posedge clk_usb); #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_ready"}, bus.rx_ready, 0);
      check({tag, "_tx_valid"}, bus.tx_valid, 0);
      check({tag, "_tx_data"}, bus.tx_data, 0);
      check({tag, "_reg_address"}, bus.reg_address, 0);
      check({tag, "_reg_bytecnt"}, bus.reg_bytecnt, 0);
      check({tag, "_reg_datai"}, bus.reg_datai, 0);
      check({tag, "_reg_read"}, bus.reg_read, 0);
      check({tag, "_reg_write"}, bus.reg_write, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_error"}, bus.error, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      int   t;
      vecs[0] = '{1'b0, 8'h05, 2,   8'hAA, 8'h11};
      vecs[1] = '{1'b1, 8'h04, 4,   8'h00, 8'h00};
      vecs[2] = '{1'b0, 8'h07, 0,   8'h00, 8'h00};
      vecs[3] = '{1'b0, 8'h21, 130, 8'h03, 8'h05};
      vecs[4] = '{1'b1, 8'h33, 3,   8'h00, 8'h00};
      vecs[5] = '{1'b0, 8'hFF, 1,   8'h7E, 8'h00};

      bus.rx_data  = 8'd0;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      reset_i      = 1'b1;
      repeat (3) @(posedge clk_usb);
      #1;
      check_all_zero("reset");
      reset_i = 1'b0;
      mon_en  = 1'b1;
      @(posedge clk_usb); #1;
      check("post_reset_rx_ready", bus.rx_ready, 1);

      for (int i = 0; i < 6; i++) begin
         begin_frame(vecs[i].addr);
         expect_frame(vecs[i].rd, vecs[i].addr, vecs[i].len, vecs[i].base, vecs[i].step);
         send_frame(vecs[i].rd, vecs[i].addr, vecs[i].len, vecs[i].base, vecs[i].step);
         if (vecs[i].len == 0) check("len0_busy", bus.busy, 0);
         wait_idle();
         check("vec_wr_cnt", wr_cnt, vecs[i].rd ? 0 : vecs[i].len);
         check("vec_rd_cnt", rd_cnt, vecs[i].rd ? vecs[i].len : 0);
         if (vecs[i].len > 0)
            check("vec_back_to_back", vecs[i].rd ? (rd_last - rd_first + 1) : (wr_last - wr_first + 1),
                  vecs[i].len);
      end
      check("no_error_yet", bus.error, 0);

      // Read under backpressure: first byte captured, then a long tx stall.
      begin_frame(8'h04);
      expect_frame(1'b1, 8'h04, 4, 8'h00, 8'h00);
      bus.tx_ready = 1'b0;
      send_frame(1'b1, 8'h04, 4, 8'h00, 8'h00);
      for (t = 0; t < 50; t++) begin
         @(negedge clk_usb);
         if (bus.tx_valid) break;
      end
      check("bp_first_byte", 32'(t < 50), 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_usb);
         check("bp_stall_read", bus.reg_read, 0);
         check("bp_stall_tx_valid", bus.tx_valid, 1);
      end
      check("bp_one_read", rd_cnt, 1);
      @(posedge clk_usb); #1;
      bus.tx_ready = 1'b1;
      wait_idle();
      check("bp_rd_cnt", rd_cnt, 4);
      check("bp_rq_empty", rq.size(), 0);

      // Malformed command byte followed by a valid one-byte write.
      begin_frame(8'h09);
      expect_frame(1'b0, 8'h09, 1, 8'h5A, 8'h00);
      send_byte(8'h40);
      bus.rx_valid = 1'b0;
      check("bad_cmd_error", bus.error, 1);
      check("bad_cmd_idle", bus.busy, 0);
      send_frame(1'b0, 8'h09, 1, 8'h5A, 8'h00);
      wait_idle();
      check("bad_cmd_error_sticky", bus.error, 1);
      check("bad_cmd_wr_cnt", wr_cnt, 1);

      // Reset after the first of three data bytes.
      begin_frame(8'h0A);
      wq.push_back('{addr: 8'h0A, bc: 7'd0, data: 8'hC1});
      send_byte(8'h00);
      send_byte(8'h0A);
      send_byte(8'h03);
      send_byte(8'hC1);
      bus.rx_valid = 1'b0;
      reset_i      = 1'b1;
      @(posedge clk_usb); #1;
      reset_i = 1'b0;
      check_all_zero("midreset");
      repeat (10) @(posedge clk_usb);
      #1;
      check("midreset_wr_cnt", wr_cnt, 1);
      check("midreset_wq_empty", wq.size(), 0);

      begin_frame(8'h0B);
      expect_frame(1'b0, 8'h0B, 3, 8'h10, 8'h01);
      send_frame(1'b0, 8'h0B, 3, 8'h10, 8'h01);
      wait_idle();
      check("after_reset_wr_cnt", wr_cnt, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
